// File: rtl/dcache_cmp_pkg.sv
// Shared types and helpers for the dcache miss comparator: default widths,
// the comparison result record and a lowest-set-bit encoder.
package dcache_cmp_pkg;

  localparam int TAG_W_DEF   = 28;
  localparam int INDEX_W_DEF = 1;

  // Result ids are carried at a fixed maximum width and cast down at the ports.
  localparam int ID_MAX_W  = 6;
  localparam int VEC_MAX_W = 1 << ID_MAX_W;

  typedef struct packed {
    logic                hit;
    logic [ID_MAX_W-1:0] way;
    logic                mshrHit;
    logic [ID_MAX_W-1:0] mshrId;
    logic                refillHit;
  } cmp_result_t;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [ID_MAX_W-1:0] lowest_set(input logic [VEC_MAX_W-1:0] vec);
    lowest_set = '0;
    for (int i = VEC_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = ID_MAX_W'(i);
    end
  endfunction

endpackage

// File: rtl/dcache_onehot_pick.sv
// Reduces a match vector to any-match, lowest matching id and a multi-match flag.
module dcache_onehot_pick
  import dcache_cmp_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    match,
  output logic            any,
  output logic [ID_W-1:0] id,
  output logic            multi
);

  logic [VEC_MAX_W-1:0] match_ext;

  // NOTE: always_comb assigns a default before any partial write so no latch is inferred.
  always_comb begin
    match_ext        = '0;
    match_ext[N-1:0] = match;
  end

  assign any   = |match;
  assign id    = ID_W'(lowest_set(match_ext));
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(match & (match - 1'b1));

endmodule

// File: rtl/dcache_miss_comparator_pipe.sv
// Two-stage tag comparator: way hit, MSHR hit and refill-buffer hit with a sticky
// multi-hit flag. Optional perf counters are enabled by DCACHE_MISS_CMP_PERF_EN.
module dcache_miss_comparator_pipe
  import dcache_cmp_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int NWAYS   = 4,
  parameter int NMSHR   = 2,
  parameter int WAY_W   = (NWAYS > 1) ? $clog2(NWAYS) : 1,
  parameter int MSHR_W  = (NMSHR > 1) ? $clog2(NMSHR) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_req_valid,
  output logic                     io_req_ready,
  input  logic [TAG_W-1:0]         io_req_tag,
  input  logic [INDEX_W-1:0]       io_req_index,
  input  logic [NWAYS*TAG_W-1:0]   io_req_wayTag,
  input  logic [NWAYS-1:0]         io_req_wayValid,
  input  logic [NMSHR-1:0]         io_mshr_valid,
  input  logic [NMSHR*TAG_W-1:0]   io_mshr_tag,
  input  logic [NMSHR*INDEX_W-1:0] io_mshr_index,
  input  logic [NMSHR-1:0]         io_mshr_refillDone,
  output logic                     io_resp_valid,
  input  logic                     io_resp_ready,
  output logic                     io_resp_hit,
  output logic [WAY_W-1:0]         io_resp_way,
  output logic                     io_resp_mshrHit,
  output logic [MSHR_W-1:0]        io_resp_mshrId,
  output logic                     io_resp_refillHit,
  output logic                     io_multiHit
`ifdef DCACHE_MISS_CMP_PERF_EN
  ,
  output logic [31:0]              io_perf_hitCnt,
  output logic [31:0]              io_perf_mshrCnt,
  output logic [31:0]              io_perf_missCnt
`endif
);

  logic                   s1_valid;
  logic [TAG_W-1:0]       s1_tag;
  logic [INDEX_W-1:0]     s1_index;
  logic [NWAYS*TAG_W-1:0] s1_way_tag;
  logic [NWAYS-1:0]       s1_way_valid;

  logic        s2_valid;
  cmp_result_t s2_res;
  cmp_result_t s1_res;
  logic        multi_hit;

  logic s2_adv;
  logic req_fire;

  logic [NWAYS-1:0]  way_match;
  logic [NMSHR-1:0]  mshr_match;
  logic              way_any, way_multi;
  logic              mshr_any, mshr_multi;
  logic [WAY_W-1:0]  way_id;
  logic [MSHR_W-1:0] mshr_id;

  assign s2_adv       = s1_valid && (!s2_valid || io_resp_ready);
  assign io_req_ready = !s1_valid || s2_adv;
  assign req_fire     = io_req_valid && io_req_ready;

  // Way tags come from the S1 copy; MSHR state is sampled live so a stalled
  // request sees allocations and frees that happen while it waits.
  always_comb begin
    way_match  = '0;
    mshr_match = '0;
    for (int i = 0; i < NWAYS; i++) begin
      way_match[i] = s1_way_valid[i] && (s1_way_tag[i*TAG_W +: TAG_W] == s1_tag);
    end
    for (int j = 0; j < NMSHR; j++) begin
      mshr_match[j] = io_mshr_valid[j]
                   && (io_mshr_tag[j*TAG_W +: TAG_W] == s1_tag)
                   && (io_mshr_index[j*INDEX_W +: INDEX_W] == s1_index);
    end
  end

  dcache_onehot_pick #(.N(NWAYS), .ID_W(WAY_W)) u_way_pick (
    .match (way_match),
    .any   (way_any),
    .id    (way_id),
    .multi (way_multi)
  );

  dcache_onehot_pick #(.N(NMSHR), .ID_W(MSHR_W)) u_mshr_pick (
    .match (mshr_match),
    .any   (mshr_any),
    .id    (mshr_id),
    .multi (mshr_multi)
  );

  always_comb begin
    s1_res           = '0;
    s1_res.hit       = way_any;
    s1_res.way       = ID_MAX_W'(way_id);
    s1_res.mshrHit   = mshr_any;
    s1_res.mshrId    = ID_MAX_W'(mshr_id);
    s1_res.refillHit = mshr_any && io_mshr_refillDone[mshr_id];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_tag       <= '0;
      s1_index     <= '0;
      s1_way_tag   <= '0;
      s1_way_valid <= '0;
    end else if (req_fire) begin
      s1_valid     <= 1'b1;
      s1_tag       <= io_req_tag;
      s1_index     <= io_req_index;
      s1_way_tag   <= io_req_wayTag;
      s1_way_valid <= io_req_wayValid;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // The result register only loads on advance, so it stays stable under backpressure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_res    <= '0;
      multi_hit <= 1'b0;
    end else if (s2_adv) begin
      s2_valid  <= 1'b1;
      s2_res    <= s1_res;
      multi_hit <= multi_hit | way_multi | mshr_multi;
    end else if (io_resp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign io_resp_valid     = s2_valid;
  assign io_resp_hit       = s2_res.hit;
  assign io_resp_way       = WAY_W'(s2_res.way);
  assign io_resp_mshrHit   = s2_res.mshrHit;
  assign io_resp_mshrId    = MSHR_W'(s2_res.mshrId);
  assign io_resp_refillHit = s2_res.refillHit;
  assign io_multiHit       = multi_hit;

`ifdef DCACHE_MISS_CMP_PERF_EN
  logic resp_fire;
  assign resp_fire = s2_valid && io_resp_ready;

  // Responses are classified with way hit taking precedence over MSHR hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_perf_hitCnt  <= '0;
      io_perf_mshrCnt <= '0;
      io_perf_missCnt <= '0;
    end else if (resp_fire) begin
      if (s2_res.hit) begin
        if (io_perf_hitCnt != '1) io_perf_hitCnt <= io_perf_hitCnt + 32'd1;
      end else if (s2_res.mshrHit) begin
        if (io_perf_mshrCnt != '1) io_perf_mshrCnt <= io_perf_mshrCnt + 32'd1;
      end else begin
        if (io_perf_missCnt != '1) io_perf_missCnt <= io_perf_missCnt + 32'd1;
      end
    end
  end
`endif

endmodule
